// File: rtl/vga_ball_pkg.sv
// Shared constants and types for the frame-synchronised ball/background registers.
package vga_ball_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    localparam logic [2:0] ADDR_R    = 3'd0;
    localparam logic [2:0] ADDR_G    = 3'd1;
    localparam logic [2:0] ADDR_B    = 3'd2;
    localparam logic [2:0] ADDR_XL   = 3'd3;
    localparam logic [2:0] ADDR_XH   = 3'd4;
    localparam logic [2:0] ADDR_YL   = 3'd5;
    localparam logic [2:0] ADDR_YH   = 3'd6;
    localparam logic [2:0] ADDR_CTRL = 3'd7;

    localparam logic [7:0] RST_R = 8'h00;
    localparam logic [7:0] RST_G = 8'h00;
    localparam logic [7:0] RST_B = 8'h80;
    localparam logic [9:0] RST_X = 10'd320;
    localparam logic [9:0] RST_Y = 10'd240;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COPY} state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [9:0] x;
        logic [9:0] y;
    } frame_t;

    function automatic logic [9:0] clamp_pos(input logic [9:0] v, input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/ball_frame_sync_if.sv
// Avalon-MM slave write path into the ball/background register block.
interface ball_frame_sync_if;
    logic [7:0] writedata;
    logic       write;
    logic       chipselect;
    logic [2:0] address;

    modport master (output writedata, write, chipselect, address);
    modport slave  (input  writedata, write, chipselect, address);
endinterface

// File: rtl/ball_frame_sync_motion.sv
// Auto-move stepper: one pixel per frame per axis, bouncing at 0 and the clamp limit.
module ball_motion #(
    parameter logic [9:0] X_MAX = 10'd624,
    parameter logic [9:0] Y_MAX = 10'd464
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       copy,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic [9:0] next_x,
    output logic [9:0] next_y
);
    logic dir_x, dir_y;     // 1 = moving towards larger coordinates
    logic nd_x, nd_y;

    // Returns {new_dir, new_pos}; at an edge the direction flips and the step goes back.
    function automatic logic [10:0] advance(input logic [9:0] pos, input logic dir,
                                            input logic [9:0] lim);
        if (dir)
            return (pos >= lim) ? {1'b0, pos - 10'd1} : {1'b1, pos + 10'd1};
        else
            return (pos == 10'd0) ? {1'b1, 10'd1} : {1'b0, pos - 10'd1};
    endfunction

    always_comb begin
        {nd_x, next_x} = advance(x, dir_x, X_MAX);
        {nd_y, next_y} = advance(y, dir_y, Y_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (copy) begin
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (step) begin
            dir_x <= nd_x;
            dir_y <= nd_y;
        end
    end
endmodule

// File: rtl/ball_frame_sync.sv
// Shadow registers for background colour and ball position, committed at the start of vblank.
// Optional BALL_AUTOMOVE_EN: the ball bounces one pixel per frame while auto-move is set.
module ball_frame_sync
    import vga_ball_pkg::*;
#(
    parameter int BALL_SIZE = 16
) (
    input  logic             clk,
    input  logic             reset,
    ball_frame_sync_if.slave bus,
    input  logic [10:0]      hcount,
    input  logic [9:0]       vcount,
    output logic [7:0]       bg_r,
    output logic [7:0]       bg_g,
    output logic [7:0]       bg_b,
    output logic [9:0]       ball_x,
    output logic [9:0]       ball_y,
    output logic             pending,
    output logic             commit
);
    localparam logic [9:0] X_MAX = 10'(H_ACTIVE - BALL_SIZE);
    localparam logic [9:0] Y_MAX = 10'(V_ACTIVE - BALL_SIZE);

    frame_t     shadow;
    logic       auto_move;
    state_t     state, state_next;
    logic       frame_tick, wr_en, commit_req, step;
    logic [9:0] next_x, next_y;

    assign frame_tick = (vcount == 10'(V_ACTIVE)) && (hcount == 11'd0);
    assign wr_en      = bus.chipselect && bus.write;
    assign commit_req = wr_en && (bus.address == ADDR_CTRL) && bus.writedata[0];
    assign step       = auto_move && (state == S_IDLE) && frame_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow    <= '{r: RST_R, g: RST_G, b: RST_B, x: RST_X, y: RST_Y};
            auto_move <= 1'b0;
        end else if (wr_en) begin
            case (bus.address)
                ADDR_R:    shadow.r      <= bus.writedata;
                ADDR_G:    shadow.g      <= bus.writedata;
                ADDR_B:    shadow.b      <= bus.writedata;
                ADDR_XL:   shadow.x[7:0] <= bus.writedata;
                ADDR_XH:   shadow.x[9:8] <= bus.writedata[1:0];
                ADDR_YL:   shadow.y[7:0] <= bus.writedata;
                ADDR_YH:   shadow.y[9:8] <= bus.writedata[1:0];
                default:   auto_move     <= bus.writedata[1];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Requests arriving while armed or copying are dropped, not queued.
    always_comb begin
        state_next = state;
        pending    = 1'b0;
        commit     = 1'b0;
        case (state)
            S_IDLE:  if (commit_req) state_next = S_ARMED;
            S_ARMED: begin
                pending = 1'b1;
                if (frame_tick) state_next = S_COPY;
            end
            S_COPY: begin
                pending    = 1'b1;
                commit     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Copy samples the shadow before any same-cycle write lands in it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bg_r   <= RST_R;
            bg_g   <= RST_G;
            bg_b   <= RST_B;
            ball_x <= RST_X;
            ball_y <= RST_Y;
        end else if (commit) begin
            bg_r   <= shadow.r;
            bg_g   <= shadow.g;
            bg_b   <= shadow.b;
            ball_x <= clamp_pos(shadow.x, X_MAX);
            ball_y <= clamp_pos(shadow.y, Y_MAX);
        end else if (step) begin
            ball_x <= next_x;
            ball_y <= next_y;
        end
    end

`ifdef BALL_AUTOMOVE_EN
    ball_motion #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_motion (
        .clk    (clk),
        .reset  (reset),
        .step   (step),
        .copy   (commit),
        .x      (ball_x),
        .y      (ball_y),
        .next_x (next_x),
        .next_y (next_y)
    );
`else
    // Auto-move bit is kept but has no effect: a step reloads the current position.
    assign next_x = ball_x;
    assign next_y = ball_y;
`endif

endmodule

// File: doc/ball_frame_sync.md
BALL_FRAME_SYNC -- requirements
Module: ball_frame_sync

Interface
REQ-001 SHALL have parameter BALL_SIZE, default 16, ball edge length in pixels.
REQ-002 SHALL have port clk, input, 1, single 50 MHz clock; all state on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports writedata in 8, write in 1, chipselect in 1, address in 3: Avalon slave write path.
REQ-005 SHALL have ports hcount in 11, vcount in 10, from the VGA counters.
REQ-006 SHALL have ports bg_r, bg_g, bg_b out 8 each: committed background colour.
REQ-007 SHALL have ports ball_x out 10, ball_y out 10: committed ball top-left pixel.
REQ-008 SHALL have ports pending out 1 (commit armed) and commit out 1 (one-cycle pulse on register copy).

Function
REQ-009 SHALL write shadow registers on chipselect&&write: addr 0 R, 1 G, 2 B, 3 X[7:0], 4 X[9:8]=writedata[1:0], 5 Y[7:0], 6 Y[9:8], 7 control.
REQ-010 SHALL treat control bit0 as commit request (self-clearing, not stored) and bit1 as auto-move enable (stored).
REQ-011 SHALL derive frame_tick = (vcount==480 && hcount==0), i.e. first cycle of vertical blank.
REQ-012 SHALL implement FSM IDLE -> ARMED on commit request; ARMED -> COPY on frame_tick; COPY -> IDLE unconditionally.
REQ-013 SHALL in COPY copy all six shadow fields to outputs and assert commit for exactly that cycle.
REQ-014 SHALL assert pending in ARMED and COPY only.
REQ-015 SHALL ignore commit requests in ARMED or COPY (no queueing, no extra commit).
REQ-016 SHALL, when request and frame_tick coincide in IDLE, enter ARMED and commit on the next frame's tick.
REQ-017 SHALL, on a shadow write in the COPY cycle, commit the pre-write value and keep the new value in shadow.
REQ-018 SHALL never change outputs outside COPY, except auto-move (REQ-022).
REQ-019 SHALL clamp committed X to 640-BALL_SIZE and Y to 480-BALL_SIZE when shadow exceeds them.

Reset
REQ-020 SHALL on reset set shadow and outputs to bg 00/00/80, ball_x 320, ball_y 240, auto-move 0, FSM IDLE, pending 0, commit 0.
REQ-021 SHALL on reset mid-ARMED abandon the commit; outputs revert to reset values.

Configuration
REQ-022 SHALL, with BALL_AUTOMOVE_EN defined, when auto-move=1 and FSM IDLE, on each frame_tick step ball_x and ball_y by +/-1 per direction bits (reset +,+), flipping a direction and stepping back instead when at 0 or the REQ-019 limit; a COPY overrides and resets directions to +,+.
REQ-023 SHALL, without BALL_AUTOMOVE_EN, store control bit1 but ignore it; positions change only in COPY.

Structure
REQ-024 SHALL place address constants, FSM state enum, H/V active sizes (640, 480) and reset colour/position constants in package vga_ball_pkg.
REQ-025 SHALL place auto-move stepping/bounce logic in sub-module ball_motion, instantiated only under BALL_AUTOMOVE_EN.

Verification
REQ-026 SHALL test: write addr0=FF, addr7=01 mid-frame -> pending=1, bg_r stays 00 until frame_tick, then bg_r=FF with a single commit pulse.
REQ-027 SHALL test: X=700 via addr3=BC, addr4=02, commit -> ball_x=624 after tick.
REQ-028 SHALL test: two commit requests in one frame -> exactly one commit pulse; second tick yields none.
REQ-029 SHALL test: commit request in the frame_tick cycle -> no copy that tick; copy on the following frame's tick.
REQ-030 SHALL test: reset asserted while ARMED -> pending=0, bg 00/00/80, no commit at next tick.
REQ-031 SHALL test (BALL_AUTOMOVE_EN): ball_x=623, auto-move=1 -> ticks give 624, 623, 622.
